// File: rtl/rsc_encoder_pkg.sv
// Shared types and helpers for the RSC encoder.
//   - FSM state and output-mode enums
//   - LTE default generator polynomials (13/15 octal, MSB = D^0)
//   - taps_of: turns a K-bit polynomial into a tap vector indexed by delay
//   - rsc_step: one trellis step, returning (a, p, fb)
package rsc_pkg;

  localparam int MAX_K = 8;

  localparam logic [3:0] LTE_G_FB = 4'b1011;
  localparam logic [3:0] LTE_G_FF = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TAIL} rsc_state_e;
  typedef enum logic {MODE_SYS_PAR = 1'b0, MODE_PAR_ONLY = 1'b1} rsc_mode_e;

  typedef struct packed {
    logic a;
    logic p;
    logic fb;
  } rsc_step_t;

  // Bit j of the result is the coefficient of D^j (bit 0 = D^0). The input is
  // zero-extended with D^0 at bit k-1, so a bit reversal plus a right shift
  // lines it up without any out-of-range indexing.
  function automatic logic [MAX_K-1:0] taps_of(input logic [MAX_K-1:0] g, input int k);
    logic [MAX_K-1:0] rev;
    for (int i = 0; i < MAX_K; i++) rev[i] = g[MAX_K-1-i];
    return rev >> (MAX_K - k);
  endfunction

  // r[j] is the feedback value delayed j steps; unused high delays are zero.
  // On a tail step the input is replaced by fb so the register input a is 0.
  function automatic rsc_step_t rsc_step(input logic u, input logic tail,
                                         input logic [MAX_K-1:1] r,
                                         input logic [MAX_K-1:1] fb_taps,
                                         input logic [MAX_K-1:0] ff_taps);
    rsc_step_t s;
    s.fb = ^(fb_taps & r);
    s.a  = (tail ? s.fb : u) ^ s.fb;
    s.p  = (ff_taps[0] & s.a) ^ (^(ff_taps[MAX_K-1:1] & r));
    return s;
  endfunction

endpackage

// File: rtl/rsc_encoder_if.sv
// Single-bit valid/ready stream with an end-of-frame marker.
//   valid/data/last : producer -> consumer
//   ready           : consumer -> producer
interface rsc_encoder_if;
  logic valid;
  logic ready;
  logic data;
  logic last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/rsc_encoder_out_slot.sv
// Two-entry output serializer. A load writes one or two bits; bit 0 is sent
// first and the slot shifts down on each accepted output.
//   clk, rst            : clock, synchronous active-high reset
//   load/load_two       : write 1 or 2 bits this cycle (only while free)
//   load_data/load_last : bits to send, and whether the last of them ends the frame
//   free                : slot can take a load this cycle
//   nonempty            : slot holds at least one bit
//   out_if              : serial output stream
module rsc_out_slot (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_two,
  input  logic          load_last,
  input  logic [1:0]    load_data,
  output logic          free,
  output logic          nonempty,
  rsc_encoder_if.master out_if
);

  logic [1:0] data_q, data_d;
  logic [1:0] last_q, last_d;
  logic [1:0] cnt_q, cnt_d;
  logic       drain;

  always_comb begin
    drain    = (cnt_q != 2'd0) && out_if.ready;
    // A single remaining bit that leaves this cycle frees the slot in time.
    free     = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && out_if.ready);
    nonempty = (cnt_q != 2'd0);
    data_d   = data_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (drain) begin
      data_d = {1'b0, data_q[1]};
      last_d = {1'b0, last_q[1]};
      cnt_d  = cnt_q - 2'd1;
    end
    if (load) begin
      data_d = load_data;
      last_d = load_two ? {load_last, 1'b0} : {1'b0, load_last};
      cnt_d  = load_two ? 2'd2 : 2'd1;
    end
    out_if.valid = nonempty;
    out_if.data  = data_q[0];
    out_if.last  = last_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rsc_encoder.sv
// Recursive systematic convolutional encoder with trellis termination.
//   clk, rst : clock, synchronous active-high reset
//   mode     : 0 = systematic+parity, 1 = parity only (taken on a frame's first bit)
//   in_if    : information bits in (data = u, last = final bit of frame)
//   out_if   : serial coded bits out (last = final tail parity bit)
//   busy     : frame in progress or output still pending
module rsc_encoder import rsc_pkg::*; #(
  parameter int           K    = 4,
  parameter logic [K-1:0] G_FB = LTE_G_FB,
  parameter logic [K-1:0] G_FF = LTE_G_FF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  rsc_encoder_if.slave  in_if,
  rsc_encoder_if.master out_if,
  output logic          busy
);

  localparam int M  = K - 1;
  localparam int CW = $clog2(K);
  localparam logic [MAX_K-1:0] FB_TAPS = taps_of(MAX_K'(G_FB), K);
  localparam logic [MAX_K-1:0] FF_TAPS = taps_of(MAX_K'(G_FF), K);

  if (K < 3 || K > MAX_K) begin : g_bad_k
    $error("rsc_encoder: K=%0d outside 3..8", K);
  end
  if (G_FB[K-1] != 1'b1) begin : g_bad_fb
    $error("rsc_encoder: G_FB D^0 coefficient must be 1");
  end

  rsc_state_e     state_q, state_d;
  rsc_mode_e      mode_q, mode_d, mode_eff;
  logic [M:1]     r_q, r_d;
  logic [CW-1:0]  tcnt_q, tcnt_d;
  logic [MAX_K-1:1] r_ext;
  rsc_step_t      st;
  logic           accept, tail_step;
  logic           slot_free, slot_busy;
  logic           load, load_two, load_last;
  logic [1:0]     load_data;

  always_comb begin
    r_ext      = '0;
    r_ext[M:1] = r_q;
    // The first bit of a frame uses the live mode pin; later bits the latched one.
    mode_eff   = (state_q == ST_IDLE) ? rsc_mode_e'(mode) : mode_q;
    in_if.ready = !rst && (state_q != ST_TAIL) && slot_free;
    accept      = in_if.valid && in_if.ready;
    tail_step   = !rst && (state_q == ST_TAIL) && slot_free;
    st = rsc_step(in_if.data, tail_step, r_ext, FB_TAPS[MAX_K-1:1], FF_TAPS);

    state_d   = state_q;
    mode_d    = mode_q;
    r_d       = r_q;
    tcnt_d    = tcnt_q;
    load      = 1'b0;
    load_two  = 1'b0;
    load_last = 1'b0;
    load_data = 2'b00;

    if (accept) begin
      r_d  = {r_q[M-1:1], st.a};
      load = 1'b1;
      if (mode_eff == MODE_PAR_ONLY) begin
        load_data = {1'b0, st.p};
      end else begin
        load_two  = 1'b1;
        load_data = {st.p, in_if.data};
      end
      if (state_q == ST_IDLE) mode_d = mode_eff;
      if (in_if.last) begin
        state_d = ST_TAIL;
        tcnt_d  = CW'(M);
      end else begin
        state_d = ST_DATA;
      end
    end else if (tail_step) begin
      // Tail input equals fb, so a = 0 and M steps flush the register.
      r_d       = {r_q[M-1:1], st.a};
      load      = 1'b1;
      load_two  = 1'b1;
      load_data = {st.p, st.fb};
      load_last = (tcnt_q == CW'(1));
      tcnt_d    = tcnt_q - CW'(1);
      // Leave TAIL as soon as the final step is loaded so the next frame can
      // be accepted while that step drains; busy stays high via the slot.
      if (tcnt_q == CW'(1)) state_d = ST_IDLE;
    end

    busy = (state_q != ST_IDLE) || slot_busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SYS_PAR;
      r_q     <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      tcnt_q  <= tcnt_d;
    end
  end

  rsc_out_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_two  (load_two),
    .load_last (load_last),
    .load_data (load_data),
    .free      (slot_free),
    .nonempty  (slot_busy),
    .out_if    (out_if)
  );

endmodule

// File: tb/tb_rsc_encoder.sv
// Bench for rsc_encoder: instance a uses the LTE defaults (K=4), instance b
// uses K=5, G_FB=10011, G_FF=11101 under random flow control.
module tb_rsc_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] iv, ib, il, md;
  logic [1:0] ir, ov, ob, ol, bsy;
  logic       ordy_a = 1'b1, ordy_b = 1'b1, rnd_b = 1'b0;
  logic       bsy_a, bsy_b;

  rsc_encoder_if ia_in();
  rsc_encoder_if ia_out();
  rsc_encoder_if ib_in();
  rsc_encoder_if ib_out();

  assign ia_in.valid  = iv[0];
  assign ia_in.data   = ib[0];
  assign ia_in.last   = il[0];
  assign ib_in.valid  = iv[1];
  assign ib_in.data   = ib[1];
  assign ib_in.last   = il[1];
  assign ia_out.ready = ordy_a;
  assign ib_out.ready = ordy_b;
  assign ir  = {ib_in.ready, ia_in.ready};
  assign ov  = {ib_out.valid, ia_out.valid};
  assign ob  = {ib_out.data, ia_out.data};
  assign ol  = {ib_out.last, ia_out.last};
  assign bsy = {bsy_b, bsy_a};

  rsc_encoder #(.K(4), .G_FB(4'b1011), .G_FF(4'b1101)) u_dut_a (
    .clk(clk), .rst(rst), .mode(md[0]), .in_if(ia_in), .out_if(ia_out), .busy(bsy_a));
  rsc_encoder #(.K(5), .G_FB(5'b10011), .G_FF(5'b11101)) u_dut_b (
    .clk(clk), .rst(rst), .mode(md[1]), .in_if(ib_in), .out_if(ib_out), .busy(bsy_b));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain polynomial arithmetic, bit j of mr = r_j.
  int         kk  [2];
  logic [7:0] gfb [2];
  logic [7:0] gff [2];
  logic [8:0] mr  [2];
  logic [1:0] qa[$], qb[$];   // expected {bit,last}

  function automatic void push(input int d, input logic [1:0] v);
    if (d == 0) qa.push_back(v); else qb.push_back(v);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic void mstep(input int d, input logic u_in, input logic tail,
                                input logic lst, input logic m1);
    int k = kk[d];
    logic fb = 1'b0;
    logic p, a, u;
    logic [8:0] nr;
    for (int j = 1; j < k; j++) fb ^= gfb[d][k-1-j] & mr[d][j];
    u = tail ? fb : u_in;
    a = u ^ fb;
    p = gff[d][k-1] & a;
    for (int j = 1; j < k; j++) p ^= gff[d][k-1-j] & mr[d][j];
    nr = mr[d] << 1;
    nr[1] = a;
    nr[0] = 1'b0;
    mr[d] = nr;
    if (tail || !m1) push(d, {u, 1'b0});
    push(d, {p, lst});
  endfunction

  // Capture of instance a output, first bit in the MSB position.
  logic [31:0] capb, capl;
  int          ncap;
  int          pop_b = 0, last_b = 0;

  always @(negedge clk) begin
    if (!rst && ov[0] && ordy_a) begin
      chk("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("a_out", 32'({ob[0], ol[0]}), 32'(qa.pop_front()));
      capb = {capb[30:0], ob[0]};
      capl = {capl[30:0], ol[0]};
      ncap++;
    end
  end

  always @(negedge clk) begin
    if (!rst && ov[1] && ordy_b) begin
      chk("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk("b_out", 32'({ob[1], ol[1]}), 32'(qb.pop_front()));
      pop_b++;
      if (ol[1]) last_b++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_b) ordy_b = ($urandom_range(3) != 0);
    else       ordy_b = 1'b1;
  end

  task automatic cap_clear();
    capb = '0; capl = '0; ncap = 0;
  endtask

  // Called and returns at a negedge; handshakes land on the following posedge.
  task automatic send_frame(input int d, input int n, input logic [63:0] bits,
                            input logic m1, input logic gaps);
    int to;
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(3) == 0) begin iv[d] = 1'b0; @(negedge clk); end
      iv[d] = 1'b1;
      ib[d] = bits[i];
      il[d] = (i == n-1);
      md[d] = (i == 0) ? m1 : 1'($urandom_range(1));  // later bits must not change mode
      to = 0;
      while (!ir[d] && to < 2000) begin @(negedge clk); to++; end
      chk("in_wait", 32'(to < 2000), 32'd1);
      mstep(d, bits[i], 1'b0, 1'b0, m1);
      if (i == n-1)
        for (int t = 1; t < kk[d]; t++) mstep(d, 1'b0, 1'b1, (t == kk[d]-1), m1);
      @(negedge clk);
    end
    iv[d] = 1'b0;
    il[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int to = 0;
    while ((qsize(d) != 0 || bsy[d]) && to < 5000) begin @(negedge clk); to++; end
    chk("drain_wait", 32'(to < 5000), 32'd1);
    chk("idle_valid", 32'(ov[d]), 32'd0);
  endtask

  task automatic chk_cap(input string tag, input int n, input logic [31:0] eb, input logic [31:0] el);
    chk({tag, "_len"}, 32'(ncap), 32'(n));
    chk({tag, "_bits"}, capb, eb);
    chk({tag, "_last"}, capl, el);
  endtask

  initial begin
    int exp_b, frames_b;
    logic hold;
    iv = '0; ib = '0; il = '0; md = '0;
    kk[0] = 4; gfb[0] = 8'b0000_1011; gff[0] = 8'b0000_1101; mr[0] = '0;
    kk[1] = 5; gfb[1] = 8'b0001_0011; gff[1] = 8'b0001_1101; mr[1] = '0;
    cap_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_bit",   32'(ob), 32'd0);
    chk("rst_last",  32'(ol), 32'd0);
    chk("rst_ready", 32'(ir), 32'd0);
    chk("rst_busy",  32'(bsy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(ir), 32'd3);

    // Frame 1,0,0,0, systematic+parity.
    cap_clear();
    send_frame(0, 4, 64'h1, 1'b0, 1'b0);
    wait_idle(0);
    chk_cap("t1", 14, 32'b11010101110111, 32'b00000000000001);

    // Same frame, parity only.
    cap_clear();
    send_frame(0, 4, 64'h1, 1'b1, 1'b0);
    wait_idle(0);
    chk_cap("t2", 10, 32'b1111110111, 32'b0000000001);

    // Single-bit frame from IDLE.
    cap_clear();
    send_frame(0, 1, 64'h1, 1'b0, 1'b0);
    wait_idle(0);
    chk_cap("t3", 8, 32'b11011011, 32'b00000001);

    // Downstream stall mid-frame.
    cap_clear();
    fork
      send_frame(0, 4, 64'h1, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 ordy_a = 1'b0;
        @(negedge clk);
        hold = ob[0];
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold",  32'(ob[0]), 32'(hold));
          chk("bp_ready", 32'(ir[0]), 32'd0);
          chk("bp_valid", 32'(ov[0]), 32'd1);
        end
        @(posedge clk);
        #1 ordy_a = 1'b1;
      end
    join
    wait_idle(0);
    chk_cap("t4", 14, 32'b11010101110111, 32'b00000000000001);

    // Reset during the second tail step, then the reference frame again.
    send_frame(0, 4, 64'h1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    qa.delete(); qb.delete(); mr[0] = '0; mr[1] = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(ov[0]), 32'd0);
    chk("mrst_bit",   32'(ob[0]), 32'd0);
    chk("mrst_last",  32'(ol[0]), 32'd0);
    chk("mrst_busy",  32'(bsy[0]), 32'd0);
    chk("mrst_ready", 32'(ir[0]), 32'd1);
    cap_clear();
    send_frame(0, 4, 64'h1, 1'b0, 1'b0);
    wait_idle(0);
    chk_cap("t5", 14, 32'b11010101110111, 32'b00000000000001);

    // K=5 random frames, random modes, random gaps and backpressure.
    rnd_b = 1'b1;
    exp_b = 0;
    frames_b = 0;
    for (int f = 0; f < 200; f++) begin
      int n;
      logic m1;
      n  = $urandom_range(64, 1);
      m1 = 1'($urandom_range(1));
      send_frame(1, n, {$urandom, $urandom}, m1, 1'b1);
      exp_b += m1 ? (n + 8) : (2*n + 8);
      frames_b++;
    end
    wait_idle(1);
    rnd_b = 1'b0;
    chk("b_total_bits", 32'(pop_b), 32'(exp_b));
    chk("b_frame_ends", 32'(last_b), 32'(frames_b));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
